// File: rtl/spike_scroller_if.sv
// Spawn handshake between the level-pattern source (master) and spike_scroller (slave).
interface spike_scroller_if;
    logic       spawn_valid;
    logic       spawn_ready;
    logic [9:0] spawn_y;
    logic       spawn_dir;

    modport master (output spawn_valid, spawn_y, spawn_dir, input spawn_ready);
    modport slave  (input spawn_valid, spawn_y, spawn_dir, output spawn_ready);
endinterface

// File: rtl/spike_scroller.sv
// Per-frame spike table: scrolls active spikes left, retires off-screen ones, takes one spawn per frame.
// Optional player collision flag enabled by defining SPIKE_SCROLLER_HIT_EN.
module spike_scroller #(
    parameter int         NUM_SPIKES  = 24,
    parameter int         SCROLL_STEP = 2,
    parameter int         SPAWN_X     = 640,
    parameter logic [9:0] PARK_X      = 10'h3FF
) (
    input  logic                  clk_125MHz,
    input  logic                  reset_n,
    input  logic                  frame_start,
    input  logic                  run,
    input  logic [9:0]            spawn_gap,
    spike_scroller_if.slave       spawn,
`ifdef SPIKE_SCROLLER_HIT_EN
    input  logic [9:0]            PlayerX,
    input  logic [9:0]            PlayerY,
    output logic                  spike_hit,
`endif
    output logic [9:0]            SpikeX         [0:NUM_SPIKES-1],
    output logic [9:0]            SpikeY         [0:NUM_SPIKES-1],
    output logic                  Draw_direction [0:NUM_SPIKES-1],
    output logic [4:0]            active_cnt,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int         IDX_W   = $clog2(NUM_SPIKES);
    localparam logic [9:0] STEP    = 10'(SCROLL_STEP);
    localparam logic [9:0] SPAWN_V = 10'(SPAWN_X);

    typedef enum logic [1:0] {IDLE, SCROLL, SPAWN, DONE} state_t;

    state_t                state, state_nxt;
    logic [IDX_W-1:0]      idx, free_idx;
    logic                  free_vld;
    logic [9:0]            gap_cnt;
    logic [NUM_SPIKES-1:0] active;
    logic                  last, cur_act, retire, xfer, spawn_ok;
    logic [9:0]            cur_x;
    logic [10:0]           gap_sum;
    logic [9:0]            gap_sat;

    assign last     = (idx == IDX_W'(NUM_SPIKES-1));
    assign cur_x    = SpikeX[idx];
    assign cur_act  = active[idx];
    assign retire   = (state == SCROLL) && cur_act && (cur_x < STEP);
    assign spawn_ok = free_vld && (gap_cnt >= spawn_gap);
    assign xfer     = spawn.spawn_valid && spawn.spawn_ready;
    assign gap_sum  = {1'b0, gap_cnt} + {1'b0, STEP};
    assign gap_sat  = gap_sum[10] ? 10'h3FF : gap_sum[9:0];

    always_ff @(posedge clk_125MHz or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;

    always_comb begin
        state_nxt         = state;
        busy              = (state != IDLE);
        frame_done        = (state == DONE);
        spawn.spawn_ready = 1'b0;
        case (state)
            IDLE:   if (frame_start && run) state_nxt = SCROLL;
            SCROLL: if (last) state_nxt = SPAWN;
            SPAWN:  begin
                spawn.spawn_ready = spawn_ok;
                state_nxt         = DONE;
            end
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pass bookkeeping: slot index, free-slot search, spawn gap and live count.
    always_ff @(posedge clk_125MHz or negedge reset_n) begin
        if (!reset_n) begin
            idx        <= '0;
            free_idx   <= '0;
            free_vld   <= 1'b0;
            gap_cnt    <= '0;
            active_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (state_nxt == SCROLL) begin
                    idx      <= '0;
                    free_vld <= 1'b0;
                end
                SCROLL: begin
                    if (!last) idx <= idx + 1'b1;
                    // A slot retired in this very cycle counts as free.
                    if (!free_vld && (!cur_act || retire)) begin
                        free_vld <= 1'b1;
                        free_idx <= idx;
                    end
                    if (last) gap_cnt <= gap_sat;
                end
                SPAWN: if (xfer) gap_cnt <= '0;
                default: ;
            endcase
            if (retire)    active_cnt <= active_cnt - 1'b1;
            else if (xfer) active_cnt <= active_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_SPIKES; g++) begin : g_slot
        logic sel, wr;
        assign sel = (state == SCROLL) && (idx == IDX_W'(g));
        assign wr  = xfer && (free_idx == IDX_W'(g));

        always_ff @(posedge clk_125MHz or negedge reset_n) begin
            if (!reset_n) begin
                SpikeX[g]         <= PARK_X;
                SpikeY[g]         <= '0;
                Draw_direction[g] <= 1'b0;
                active[g]         <= 1'b0;
            end else if (wr) begin
                SpikeX[g]         <= SPAWN_V;
                SpikeY[g]         <= spawn.spawn_y;
                Draw_direction[g] <= spawn.spawn_dir;
                active[g]         <= 1'b1;
            end else if (sel && active[g]) begin
                if (SpikeX[g] < STEP) begin
                    SpikeX[g]         <= PARK_X;
                    SpikeY[g]         <= '0;
                    Draw_direction[g] <= 1'b0;
                    active[g]         <= 1'b0;
                end else begin
                    SpikeX[g] <= SpikeX[g] - STEP;
                end
            end
        end
    end

`ifdef SPIKE_SCROLLER_HIT_EN
    // Spike and player are both 20x20 boxes anchored at their top-left corner.
    logic [9:0] post_x;
    logic       overlap;
    assign post_x  = cur_x - STEP;
    assign overlap = ({1'b0, post_x} < {1'b0, PlayerX} + 11'd20) &&
                     ({1'b0, PlayerX} < {1'b0, post_x} + 11'd20) &&
                     ({1'b0, SpikeY[idx]} < {1'b0, PlayerY} + 11'd20) &&
                     ({1'b0, PlayerY} < {1'b0, SpikeY[idx]} + 11'd20);

    always_ff @(posedge clk_125MHz or negedge reset_n)
        if (!reset_n)                                        spike_hit <= 1'b0;
        else if (state == IDLE && state_nxt == SCROLL)       spike_hit <= 1'b0;
        else if (state == SCROLL && cur_act && !retire && overlap) spike_hit <= 1'b1;
`endif
endmodule

// File: tb/tb_spike_scroller.sv
// Directed bench for spike_scroller: a default instance plus one with SPAWN_X=5 for retirement.
module tb_spike_scroller;
    localparam int N = 24;

    logic       clk = 1'b0;
    logic       reset_n, frame_start, run;
    logic [9:0] spawn_gap;
    logic [9:0] x0 [0:N-1], y0 [0:N-1], x1 [0:N-1], y1 [0:N-1];
    logic       d0 [0:N-1], d1 [0:N-1];
    logic [4:0] cnt0, cnt1;
    logic       busy0, busy1, done0, done1;

    int   n_chk = 0, n_err = 0;
    logic last_ready;
    int   dc;

    spike_scroller_if if0 ();
    spike_scroller_if if1 ();

    always #4 clk = ~clk;

    spike_scroller u0 (
        .clk_125MHz(clk), .reset_n(reset_n), .frame_start(frame_start), .run(run),
        .spawn_gap(spawn_gap), .spawn(if0),
        .SpikeX(x0), .SpikeY(y0), .Draw_direction(d0),
        .active_cnt(cnt0), .busy(busy0), .frame_done(done0));

    spike_scroller #(.SPAWN_X(5)) u1 (
        .clk_125MHz(clk), .reset_n(reset_n), .frame_start(frame_start), .run(run),
        .spawn_gap(spawn_gap), .spawn(if1),
        .SpikeX(x1), .SpikeY(y1), .Draw_direction(d1),
        .active_cnt(cnt1), .busy(busy1), .frame_done(done1));

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Starts and ends on a falling edge; dc = cycle on which frame_done was seen.
    task automatic frame(output int done_cyc);
        frame_start = 1'b1;
        @(posedge clk);
        #1 frame_start = 1'b0;
        done_cyc = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == N + 1) last_ready = if0.spawn_ready;
            if (done0) begin
                done_cyc = k;
                break;
            end
        end
        @(negedge clk);
    endtask

    function automatic int parked0();
        int n = 0;
        for (int i = 0; i < N; i++) if (x0[i] !== 10'h3FF) n++;
        return n;
    endfunction

    initial begin
        int   ndone, dk;
        logic rdy, saw_busy;
        logic exp_rdy [0:5];
        exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        reset_n = 1'b0; frame_start = 1'b0; run = 1'b1; spawn_gap = 10'd0;
        if0.spawn_valid = 1'b0; if0.spawn_y = '0; if0.spawn_dir = 1'b0;
        if1.spawn_valid = 1'b0; if1.spawn_y = '0; if1.spawn_dir = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_unparked", parked0(), 0);
        chk("rst_cnt", int'(cnt0), 0);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_ready", int'(if0.spawn_ready), 0);
        chk("rst_done", int'(done0), 0);

        // First spawn into slot 0 of both instances
        if0.spawn_valid = 1'b1; if0.spawn_y = 10'd300; if0.spawn_dir = 1'b1;
        if1.spawn_valid = 1'b1; if1.spawn_y = 10'd50;  if1.spawn_dir = 1'b0;
        frame(dc);
        if0.spawn_valid = 1'b0; if1.spawn_valid = 1'b0;
        chk("a_done_cyc", dc, 26);
        chk("a_ready", int'(last_ready), 1);
        chk("a_x0", int'(x0[0]), 640);
        chk("a_y0", int'(y0[0]), 300);
        chk("a_d0", int'(d0[0]), 1);
        chk("a_cnt", int'(cnt0), 1);
        chk("a_x1", int'(x1[0]), 5);
        chk("a_x0s1", int'(x0[1]), 10'h3FF);

        // Retirement on the SPAWN_X=5 instance: 5 -> 3 -> 1 -> parked
        frame(dc);
        chk("b_x1", int'(x1[0]), 3);
        frame(dc);
        chk("c_x1", int'(x1[0]), 1);
        frame(dc);
        chk("d_x1", int'(x1[0]), 10'h3FF);
        chk("d_y1", int'(y1[0]), 0);
        chk("d_cnt1", int'(cnt1), 0);
        if1.spawn_valid = 1'b1; if1.spawn_y = 10'd77; if1.spawn_dir = 1'b1;
        frame(dc);
        if1.spawn_valid = 1'b0;
        chk("e_x1", int'(x1[0]), 5);
        chk("e_y1", int'(y1[0]), 77);
        chk("e_d1", int'(d1[0]), 1);
        chk("e_x1s1", int'(x1[1]), 10'h3FF);
        chk("e_cnt1", int'(cnt1), 1);
        chk("e_x0", int'(x0[0]), 632);

        // Spawn gap 10 with step 2: one acceptance every 5th frame
        spawn_gap = 10'd10;
        if0.spawn_valid = 1'b1; if0.spawn_y = 10'd100; if0.spawn_dir = 1'b0;
        for (int f = 0; f < 6; f++) begin
            frame(dc);
            chk($sformatf("gap_ready_f%0d", f), int'(last_ready), int'(exp_rdy[f]));
        end
        chk("gap_cnt", int'(cnt0), 3);
        chk("gap_x_s1", int'(x0[1]), 630);
        chk("gap_x_s2", int'(x0[2]), 640);
        chk("gap_y_s2", int'(y0[2]), 100);

        // Fill the remaining 21 slots
        spawn_gap = 10'd0;
        for (int f = 0; f < 21; f++) frame(dc);
        chk("fill_cnt", int'(cnt0), 24);
        chk("fill_x23", int'(x0[23]), 640);
        chk("fill_ready", int'(last_ready), 1);

        // Full table, with a second frame_start dropped mid-pass
        frame_start = 1'b1;
        @(posedge clk);
        #1 frame_start = 1'b0;
        ndone = 0; dk = -1; rdy = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 5) frame_start = 1'b1;
            if (k == 6) frame_start = 1'b0;
            if (k == N + 1) rdy = if0.spawn_ready;
            if (done0) begin ndone++; dk = k; end
        end
        chk("full_ndone", ndone, 1);
        chk("full_done_cyc", dk, 26);
        chk("full_ready", int'(rdy), 0);
        chk("full_cnt", int'(cnt0), 24);
        chk("full_x23", int'(x0[23]), 638);
        chk("full_x0", int'(x0[0]), 576);
        chk("full_busy", int'(busy0), 0);

        // run = 0: frame_start ignored
        run = 1'b0;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        saw_busy = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (busy0) saw_busy = 1'b1;
        end
        chk("norun_busy", int'(saw_busy), 0);
        chk("norun_x0", int'(x0[0]), 576);
        chk("norun_cnt", int'(cnt0), 24);
        run = 1'b1;

        // Asynchronous reset at SCROLL cycle 10
        if0.spawn_valid = 1'b0;
        frame_start = 1'b1;
        @(posedge clk);
        #1 frame_start = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_busy", int'(busy0), 1);
        reset_n = 1'b0;
        #1;
        chk("arst_unparked", parked0(), 0);
        chk("arst_y0", int'(y0[0]), 0);
        chk("arst_d0", int'(d0[0]), 0);
        chk("arst_cnt", int'(cnt0), 0);
        chk("arst_busy", int'(busy0), 0);
        chk("arst_done", int'(done0), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        frame(dc);
        chk("post_done_cyc", dc, 26);
        chk("post_cnt", int'(cnt0), 0);
        chk("post_unparked", parked0(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
